// File: rtl/vga_fb_arbiter.sv
// Frame-buffer arbiter: shares one single-port synchronous pixel RAM between
// VGA scanout reads (fixed 3-cycle latency, always win) and a buffered pixel
// writer whose beats drain into cycles where scanout is idle.

package vga_pkg;
  typedef struct packed {
    int unsigned WIDTH;
    int unsigned HEIGHT;
    int unsigned COL_BITS;
  } vga_res_cfg_t;

  localparam vga_res_cfg_t VGA_RESOLUTION_640X480_4BIT =
    '{WIDTH: 640, HEIGHT: 480, COL_BITS: 4};
endpackage

module vga_fb_arbiter
  import vga_pkg::*;
#(
  parameter vga_res_cfg_t CFG    = VGA_RESOLUTION_640X480_4BIT,
  parameter int unsigned  DEPTH  = 4,
  localparam int unsigned WIDTH  = CFG.WIDTH,
  localparam int unsigned HEIGHT = CFG.HEIGHT,
  localparam int unsigned ADDR_W = $clog2(CFG.WIDTH * CFG.HEIGHT),
  localparam int unsigned RW     = $clog2(CFG.HEIGHT),
  localparam int unsigned CW     = $clog2(CFG.WIDTH),
  localparam int unsigned PW     = 3 * CFG.COL_BITS,
  localparam int unsigned LW     = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              scan_req,
  input  logic [RW-1:0]     scan_row,
  input  logic [CW-1:0]     scan_col,
  output logic [PW-1:0]     scan_rgb,
  output logic              scan_valid,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [RW-1:0]     wr_row,
  input  logic [CW-1:0]     wr_col,
  input  logic [PW-1:0]     wr_rgb,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [PW-1:0]     ram_wdata,
  input  logic [PW-1:0]     ram_rdata,
  output logic [LW-1:0]     fifo_level,
  output logic              drop_err,
  input  logic              err_clr
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [PW-1:0]     pix_t;

  // A coordinate addresses the frame only when both axes are inside it.
  function automatic logic in_range(input logic [RW-1:0] row, input logic [CW-1:0] col);
    return (32'(row) < HEIGHT) && (32'(col) < WIDTH);
  endfunction

  // Row-major linear address, formed wide and then cut to the RAM width.
  function automatic addr_t lin_addr(input logic [RW-1:0] row, input logic [CW-1:0] col);
    logic [31:0] full;
    full = 32'(row) * WIDTH + 32'(col);
    return full[ADDR_W-1:0];
  endfunction

  logic             run_q;
  addr_t            fifo_addr [DEPTH];
  pix_t             fifo_data [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             fifo_empty;

  logic             scan_ok;
  logic             wr_ok;
  addr_t            scan_addr;
  addr_t            wr_addr;
  logic             accept;
  logic             push;
  logic             pop;
  logic             drop;

  logic             en_n;
  logic             we_n;
  addr_t            addr_n;
  pix_t             wdata_n;

  logic             vld_p0;
  logic             inr_p0;
  logic             vld_p1;
  logic             inr_p1;

  // Ready depends only on registers, so the writer never sees a combinational
  // path from its own valid or from scan_req.
  assign wr_ready   = run_q && (fifo_level != LW'(DEPTH));
  assign fifo_empty = (fifo_level == '0);

  assign scan_ok    = in_range(scan_row, scan_col);
  assign scan_addr  = lin_addr(scan_row, scan_col);
  assign wr_ok      = in_range(wr_row, wr_col);
  assign wr_addr    = lin_addr(wr_row, wr_col);

  // Out-of-range beats complete the handshake but never enter the FIFO.
  assign accept     = wr_valid && wr_ready;
  assign push       = accept && wr_ok;
  assign drop       = accept && !wr_ok;
  assign pop        = !scan_req && !fifo_empty;

  // Fixed-priority arbitration: scan read, else FIFO head write, else idle.
  always_comb begin
    en_n    = 1'b0;
    we_n    = 1'b0;
    addr_n  = ram_addr;
    wdata_n = ram_wdata;
    if (scan_req) begin
      if (scan_ok) begin
        en_n   = 1'b1;
        addr_n = scan_addr;
      end
    end else if (!fifo_empty) begin
      en_n    = 1'b1;
      we_n    = 1'b1;
      addr_n  = fifo_addr[rd_ptr];
      wdata_n = fifo_data[rd_ptr];
    end
  end

  // Stage p0: the arbitration decision lands on the RAM command pins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_en    <= 1'b0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
    end else begin
      ram_en    <= en_n;
      ram_we    <= we_n;
      ram_addr  <= addr_n;
      ram_wdata <= wdata_n;
    end
  end

  // FIFO payload storage; only the pointers and level need a reset.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wr_ptr] <= wr_addr;
      fifo_data[wr_ptr] <= wr_rgb;
    end
  end

  // FIFO pointers and occupancy; push and pop together leave the level alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + LW'(1);
        2'b01:   fifo_level <= fifo_level - LW'(1);
        default: fifo_level <= fifo_level;
      endcase
    end
  end

  // Scan tracking: p0 marks the cycle the strobe is on the pins, p1 the cycle
  // read data is returned; out-of-range requests ride along to yield zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p0 <= 1'b0;
      inr_p0 <= 1'b0;
      vld_p1 <= 1'b0;
      inr_p1 <= 1'b0;
    end else begin
      // Stage p0: request accepted, strobe on pins.
      vld_p0 <= scan_req;
      inr_p0 <= scan_req && scan_ok;
      // Stage p1: RAM read data present.
      vld_p1 <= vld_p0;
      inr_p1 <= inr_p0;
    end
  end

  // Stage p2: registered pixel returned to the scanout path.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_valid <= 1'b0;
      scan_rgb   <= '0;
    end else begin
      scan_valid <= vld_p1;
      if (vld_p1) scan_rgb <= inr_p1 ? ram_rdata : '0;
    end
  end

  // Sticky drop flag; a new drop outranks a clear in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_err <= 1'b0;
    end else if (drop) begin
      drop_err <= 1'b1;
    end else if (err_clr) begin
      drop_err <= 1'b0;
    end
  end

  // Writer is held off until the first clock after reset is released.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) run_q <= 1'b0;
    else        run_q <= 1'b1;
  end

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Bench for vga_fb_arbiter: directed scenarios plus randomized traffic, all
// checked against a transaction-level model (pending-write queue, expected
// scan results, and a golden frame image).

module tb_vga_fb_arbiter;
  import vga_pkg::*;

  localparam vga_res_cfg_t CFG = VGA_RESOLUTION_640X480_4BIT;
  localparam int DEPTH  = 4;
  localparam int WIDTH  = 640;
  localparam int HEIGHT = 480;
  localparam int ADDR_W = 19;
  localparam int RW     = 9;
  localparam int CW     = 10;
  localparam int PW     = 12;
  localparam int LW     = 3;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              scan_req = 1'b0;
  logic [RW-1:0]     scan_row = '0;
  logic [CW-1:0]     scan_col = '0;
  logic [PW-1:0]     scan_rgb;
  logic              scan_valid;
  logic              wr_valid = 1'b0;
  logic              wr_ready;
  logic [RW-1:0]     wr_row = '0;
  logic [CW-1:0]     wr_col = '0;
  logic [PW-1:0]     wr_rgb = '0;
  logic              ram_en;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [PW-1:0]     ram_wdata;
  logic [PW-1:0]     ram_rdata;
  logic [LW-1:0]     fifo_level;
  logic              drop_err;
  logic              err_clr = 1'b0;

  vga_fb_arbiter #(.CFG(CFG), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .scan_req(scan_req), .scan_row(scan_row), .scan_col(scan_col),
    .scan_rgb(scan_rgb), .scan_valid(scan_valid),
    .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_row(wr_row), .wr_col(wr_col), .wr_rgb(wr_rgb),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .fifo_level(fifo_level), .drop_err(drop_err), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  // Single-port synchronous RAM, one-cycle read latency, zero-filled.
  bit [PW-1:0] mem [0:(1<<ADDR_W)-1];
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      else        ram_rdata <= mem[ram_addr];
    end
  end

  typedef struct { int addr; logic [PW-1:0] rgb; } wr_t;
  typedef struct { int due;  logic [PW-1:0] rgb; } rd_t;

  wr_t           q[$];
  rd_t           rq[$];
  logic [PW-1:0] golden [int];
  bit            run;
  bit            drop;
  int            cyc;
  bit            e_en;
  bit            e_we;
  int            e_addr;
  logic [PW-1:0] e_wdata;
  int            vectors;
  int            miscompares;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [PW-1:0] gold_rd(input int a);
    return golden.exists(a) ? golden[a] : '0;
  endfunction

  task automatic set_scan(input bit v, input int r, input int c);
    scan_req = v; scan_row = RW'(r); scan_col = CW'(c);
  endtask

  task automatic set_wr(input bit v, input int r, input int c, input int rgb);
    wr_valid = v; wr_row = RW'(r); wr_col = CW'(c); wr_rgb = PW'(rgb);
  endtask

  // One clock: apply the arbitration rules to the current inputs, then
  // compare every DUT output against the model just after the edge.
  task automatic tick();
    bit  acc, ok_w, ok_s;
    int  a, now;
    wr_t w;
    rd_t r;
    acc  = wr_valid && run && (q.size() != DEPTH);
    e_en = 1'b0;
    e_we = 1'b0;
    if (scan_req) begin
      ok_s  = (int'(scan_row) < HEIGHT) && (int'(scan_col) < WIDTH);
      a     = int'(scan_row) * WIDTH + int'(scan_col);
      r.due = cyc + 2;
      r.rgb = ok_s ? gold_rd(a) : '0;
      rq.push_back(r);
      if (ok_s) begin e_en = 1'b1; e_addr = a; end
    end else if (q.size() > 0) begin
      w = q.pop_front();
      golden[w.addr] = w.rgb;
      e_en = 1'b1; e_we = 1'b1; e_addr = w.addr; e_wdata = w.rgb;
    end
    if (acc) begin
      ok_w = (int'(wr_row) < HEIGHT) && (int'(wr_col) < WIDTH);
      if (ok_w) begin
        w.addr = int'(wr_row) * WIDTH + int'(wr_col);
        w.rgb  = wr_rgb;
        q.push_back(w);
      end else begin
        drop = 1'b1;
      end
    end
    if (!(acc && !ok_w) && err_clr) drop = 1'b0;
    now = cyc;
    @(posedge clk); #1;
    cyc++;
    run = 1'b1;
    chk("ram_en", 32'(ram_en), 32'(e_en));
    if (e_en) begin
      chk("ram_we", 32'(ram_we), 32'(e_we));
      chk("ram_addr", 32'(ram_addr), e_addr);
      if (e_we) chk("ram_wdata", 32'(ram_wdata), 32'(e_wdata));
    end
    chk("fifo_level", 32'(fifo_level), q.size());
    chk("wr_ready", 32'(wr_ready), 32'(q.size() != DEPTH));
    chk("drop_err", 32'(drop_err), 32'(drop));
    if (rq.size() > 0 && rq[0].due == now) begin
      chk("scan_valid", 32'(scan_valid), 32'd1);
      chk("scan_rgb", 32'(scan_rgb), 32'(rq[0].rgb));
      void'(rq.pop_front());
    end else begin
      chk("scan_valid", 32'(scan_valid), 32'd0);
    end
  endtask

  task automatic apply_reset();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_ram_en", 32'(ram_en), 32'd0);
    chk("rst_ram_we", 32'(ram_we), 32'd0);
    chk("rst_ram_addr", 32'(ram_addr), 32'd0);
    chk("rst_ram_wdata", 32'(ram_wdata), 32'd0);
    chk("rst_scan_rgb", 32'(scan_rgb), 32'd0);
    chk("rst_scan_valid", 32'(scan_valid), 32'd0);
    chk("rst_fifo_level", 32'(fifo_level), 32'd0);
    chk("rst_drop_err", 32'(drop_err), 32'd0);
    chk("rst_wr_ready", 32'(wr_ready), 32'd0);
    q.delete();
    rq.delete();
    run  = 1'b0;
    drop = 1'b0;
    set_scan(0, 0, 0);
    set_wr(0, 0, 0, 0);
    err_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1 chk("rst_hold_wr_ready", 32'(wr_ready), 32'd0);
    @(negedge clk) rst_n = 1'b1;
  endtask

  initial begin
    vectors = 0; miscompares = 0; cyc = 0; run = 1'b0; drop = 1'b0;

    // Power-on reset, then one idle cycle brings wr_ready up.
    apply_reset();
    tick();
    tick();

    // Single write, then read it back.
    set_wr(1, 1, 2, 'hABC);
    tick();
    set_wr(0, 0, 0, 0);
    tick();
    chk("single_en", 32'(ram_en), 32'd1);
    chk("single_we", 32'(ram_we), 32'd1);
    chk("single_addr", 32'(ram_addr), 32'd642);
    chk("single_wdata", 32'(ram_wdata), 32'hABC);
    tick();
    set_scan(1, 1, 2);
    tick();
    set_scan(0, 0, 0);
    tick();
    tick();
    chk("readback_valid", 32'(scan_valid), 32'd1);
    chk("readback_rgb", 32'(scan_rgb), 32'hABC);
    tick();

    // Priority: scan held for 10 cycles while 4 writes fill the FIFO.
    for (int i = 0; i < 10; i++) begin
      set_scan(1, $urandom_range(0, HEIGHT-1), $urandom_range(0, WIDTH-1));
      if (i < 4) set_wr(1, $urandom_range(0, HEIGHT-1), $urandom_range(0, WIDTH-1), $urandom);
      else       set_wr(1, 7, 7, 'h123);
      tick();
      if (i == 3) begin
        chk("prio_level_full", 32'(fifo_level), 32'd4);
        chk("prio_ready_low", 32'(wr_ready), 32'd0);
      end
    end
    set_scan(0, 0, 0);
    set_wr(0, 0, 0, 0);
    repeat (4) tick();
    chk("prio_drained", 32'(fifo_level), 32'd0);
    repeat (3) tick();

    // Streaming scan along the last row.
    for (int c = 0; c < WIDTH; c++) begin
      set_scan(1, HEIGHT-1, c);
      tick();
    end
    chk("stream_last_addr", 32'(ram_addr), 32'd307199);
    set_scan(0, 0, 0);
    repeat (3) tick();

    // Out-of-range write, clear, out-of-range scan.
    set_wr(1, 0, 640, 'h555);
    tick();
    chk("oor_wr_drop", 32'(drop_err), 32'd1);
    chk("oor_wr_level", 32'(fifo_level), 32'd0);
    set_wr(0, 0, 0, 0);
    repeat (2) tick();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("oor_clr", 32'(drop_err), 32'd0);
    set_scan(1, 480, 0);
    tick();
    chk("oor_scan_no_en", 32'(ram_en), 32'd0);
    set_scan(0, 0, 0);
    tick();
    tick();
    chk("oor_scan_valid", 32'(scan_valid), 32'd1);
    chk("oor_scan_rgb", 32'(scan_rgb), 32'd0);
    tick();

    // Push and pop together at level 2; drop beats clear in the same cycle.
    set_scan(1, 0, 0);
    set_wr(1, 5, 5, 'h111);
    tick();
    set_wr(1, 5, 6, 'h222);
    tick();
    set_scan(0, 0, 0);
    set_wr(1, 5, 7, 'h333);
    tick();
    chk("pushpop_level", 32'(fifo_level), 32'd2);
    set_wr(1, 480, 0, 'h444);
    err_clr = 1'b1;
    tick();
    chk("set_beats_clr", 32'(drop_err), 32'd1);
    set_wr(0, 0, 0, 0);
    err_clr = 1'b0;
    repeat (5) tick();

    // Randomized traffic in a small window so reads hit recent writes.
    for (int blk = 0; blk < 30; blk++) begin
      int scan_pct;
      scan_pct = $urandom_range(10, 95);
      for (int k = 0; k < 100; k++) begin
        if ($urandom_range(0, 99) < scan_pct) begin
          if ($urandom_range(0, 9) == 0) set_scan(1, $urandom_range(480, 511), $urandom_range(0, 1023));
          else                           set_scan(1, $urandom_range(0, 3), $urandom_range(0, 7));
        end else begin
          set_scan(0, 0, 0);
        end
        if ($urandom_range(0, 1) == 1) begin
          if ($urandom_range(0, 9) == 0) set_wr(1, $urandom_range(0, 3), $urandom_range(640, 1023), $urandom);
          else                           set_wr(1, $urandom_range(0, 3), $urandom_range(0, 7), $urandom);
        end else begin
          set_wr(0, 0, 0, 0);
        end
        err_clr = ($urandom_range(0, 7) == 0);
        tick();
      end
    end
    set_scan(0, 0, 0);
    set_wr(0, 0, 0, 0);
    err_clr = 1'b0;
    repeat (8) tick();

    // Reset with writes queued and scans in flight.
    for (int i = 0; i < 3; i++) begin
      set_scan(1, $urandom_range(0, 3), $urandom_range(0, 7));
      set_wr(1, $urandom_range(0, 3), $urandom_range(0, 7), $urandom);
      tick();
    end
    chk("mid_level3", 32'(fifo_level), 32'd3);
    apply_reset();
    tick();
    chk("mid_level0", 32'(fifo_level), 32'd0);
    repeat (5) tick();
    for (int i = 0; i < 4; i++) begin
      set_scan(1, $urandom_range(0, 3), $urandom_range(0, 7));
      tick();
    end
    set_scan(0, 0, 0);
    repeat (4) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
